// File: rtl/vec_pkg.sv
// Shared types and defaults for the vector packed add/sub sequencer.
package vec_pkg;

    localparam int unsigned VLEN_MAX_DEFAULT = 16;
    localparam int unsigned REG_W_DEFAULT    = 5;
    localparam int unsigned DATA_W           = 32;

    typedef enum logic [1:0] {
        PK_WORD = 2'b00,
        PK_HALF = 2'b01,
        PK_BYTE = 2'b10,
        PK_ILL  = 2'b11
    } pack_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        FIN   = 2'b11
    } seq_state_e;

endpackage

// File: rtl/vec_addsub_seq_if.sv
// Command, register-file read and write-back signals of the sequencer.
interface vec_addsub_seq_if
    import vec_pkg::*;
#(
    parameter int unsigned IDX_W = $clog2(VLEN_MAX_DEFAULT),
    parameter int unsigned REG_W = REG_W_DEFAULT
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_sub;
    logic [1:0]        cmd_pack;
    logic [REG_W-1:0]  cmd_vd;
    logic [REG_W-1:0]  cmd_va;
    logic [REG_W-1:0]  cmd_vb;
    logic [IDX_W:0]    cmd_vl;

    logic              rd_en;
    logic              rd_gnt;
    logic [REG_W-1:0]  rd_reg_a;
    logic [REG_W-1:0]  rd_reg_b;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;

    logic              wr_en;
    logic [REG_W-1:0]  wr_reg;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    logic              busy;
    logic              done;
    logic              err;

    // Issue stage and register file side
    modport master (
        output cmd_valid, cmd_sub, cmd_pack, cmd_vd, cmd_va, cmd_vb, cmd_vl,
        output rd_gnt, rd_data_a, rd_data_b,
        input  cmd_ready, rd_en, rd_reg_a, rd_reg_b, rd_idx,
        input  wr_en, wr_reg, wr_idx, wr_data, busy, done, err
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_sub, cmd_pack, cmd_vd, cmd_va, cmd_vb, cmd_vl,
        input  rd_gnt, rd_data_a, rd_data_b,
        output cmd_ready, rd_en, rd_reg_a, rd_reg_b, rd_idx,
        output wr_en, wr_reg, wr_idx, wr_data, busy, done, err
    );

endinterface

// File: rtl/packed_addsub.sv
// Combinational packed add/sub: one 32-bit word, two 16-bit or four 8-bit lanes.
module packed_addsub
    import vec_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    input  pack_mode_e        pack_i,
    output logic [DATA_W-1:0] res_o
);

    // Lane-wise arithmetic; each lane wraps on its own, no carry crosses lanes
    always_comb begin
        res_o = '0;
        case (pack_i)
            PK_WORD: begin
                res_o = sub_i ? (a_i - b_i) : (a_i + b_i);
            end
            PK_HALF: begin
                for (int l = 0; l < 2; l++) begin
                    res_o[16*l +: 16] = sub_i ? (a_i[16*l +: 16] - b_i[16*l +: 16])
                                              : (a_i[16*l +: 16] + b_i[16*l +: 16]);
                end
            end
            PK_BYTE: begin
                for (int l = 0; l < 4; l++) begin
                    res_o[8*l +: 8] = sub_i ? (a_i[8*l +: 8] - b_i[8*l +: 8])
                                            : (a_i[8*l +: 8] + b_i[8*l +: 8]);
                end
            end
            default: begin
                res_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/vec_addsub_seq.sv
// Streams VL element pairs from the vector register file through one packed
// add/sub and writes the results back in element order, one element per cycle.
module vec_addsub_seq
    import vec_pkg::*;
#(
    parameter int unsigned VLEN_MAX = VLEN_MAX_DEFAULT,
    parameter int unsigned IDX_W    = $clog2(VLEN_MAX),
    parameter int unsigned REG_W    = REG_W_DEFAULT
)(
    input  logic             clk,
    input  logic             rst_n,
    vec_addsub_seq_if.slave  bus
);

    // Counter is one bit wider than an index so VL == VLEN_MAX never wraps
    localparam int unsigned      CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] VL_MAX_C = CNT_W'(VLEN_MAX);

    seq_state_e        state_q;
    logic              cmd_ready_q;
    logic              busy_q;
    logic              rd_en_q;
    logic              done_q;
    logic              err_q;
    logic              sub_q;
    pack_mode_e        pack_q;
    logic [REG_W-1:0]  vd_q;
    logic [REG_W-1:0]  va_q;
    logic [REG_W-1:0]  vb_q;
    logic [CNT_W-1:0]  vl_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              s1_valid_q;
    logic [IDX_W-1:0]  s1_idx_q;
    logic              wr_en_q;
    logic [IDX_W-1:0]  wr_idx_q;
    logic [DATA_W-1:0] wr_data_q;

    pack_mode_e        cmd_pack_c;
    logic [CNT_W-1:0]  cmd_vl_c;
    logic              grant_c;
    logic              last_c;
    logic [DATA_W-1:0] res_c;

    // Command decode, VL clamp and read-grant qualification
    assign cmd_pack_c = pack_mode_e'(bus.cmd_pack);
    assign cmd_vl_c   = (bus.cmd_vl > VL_MAX_C) ? VL_MAX_C : bus.cmd_vl;
    assign grant_c    = (state_q == RUN) && bus.rd_gnt;
    assign cnt_d      = cnt_q + CNT_W'(1);
    assign last_c     = (cnt_d == vl_q);

    // Sequencer FSM with registered handshake, read and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sub_q       <= 1'b0;
            pack_q      <= PK_WORD;
            vd_q        <= '0;
            va_q        <= '0;
            vb_q        <= '0;
            vl_q        <= '0;
            cnt_q       <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        sub_q       <= bus.cmd_sub;
                        pack_q      <= cmd_pack_c;
                        vd_q        <= bus.cmd_vd;
                        va_q        <= bus.cmd_va;
                        vb_q        <= bus.cmd_vb;
                        vl_q        <= cmd_vl_c;
                        cnt_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        // Empty or illegal commands skip straight to completion
                        if ((cmd_vl_c == '0) || (cmd_pack_c == PK_ILL)) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            err_q   <= (cmd_pack_c == PK_ILL);
                        end else begin
                            state_q <= RUN;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.rd_gnt) begin
                        if (last_c) begin
                            state_q <= DRAIN;
                            rd_en_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                DRAIN: begin
                    // Stage 2 holds the final write this cycle once stage 1 is empty
                    if (!s1_valid_q) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Single packed add/sub between the read stage and the write-back stage
    packed_addsub u_addsub (
        .a_i    (bus.rd_data_a),
        .b_i    (bus.rd_data_b),
        .sub_i  (sub_q),
        .pack_i (pack_q),
        .res_o  (res_c)
    );

    // Two-stage pipeline: grant -> operand return -> registered write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            s1_valid_q <= grant_c;
            if (grant_c) begin
                s1_idx_q <= IDX_W'(cnt_q);
            end
            wr_en_q <= s1_valid_q;
            if (s1_valid_q) begin
                wr_idx_q  <= s1_idx_q;
                wr_data_q <= res_c;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_reg_a  = va_q;
    assign bus.rd_reg_b  = vb_q;
    assign bus.rd_idx    = IDX_W'(cnt_q);
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_reg    = vd_q;
    assign bus.wr_idx    = wr_idx_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_vec_addsub_seq.sv
// Directed bench for vec_addsub_seq: a vector table for the arithmetic plus
// hand-written sequences for timing, stalls, edge lengths and reset.
module tb_vec_addsub_seq;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned REG_W = 5;

    logic clk;
    logic rst_n;

    vec_addsub_seq_if #(.IDX_W(IDX_W), .REG_W(REG_W)) bus ();

    vec_addsub_seq #(.VLEN_MAX(16), .IDX_W(IDX_W), .REG_W(REG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Cycle counter and per-command event logs (cycles relative to accept)
    int          cyc = 0;
    int          t0 = 0;
    int          mon_rel;
    logic [31:0] deny = '0;
    logic [31:0] opa [16];
    logic [31:0] opb [16];

    int          rd_n, wr_n, done_n, done_rel, rdy_rel;
    logic        done_err;
    int          rd_rel [64];
    logic [3:0]  rd_ix  [64];
    int          wr_rel [64];
    logic [3:0]  wr_ix  [64];
    logic [31:0] wr_dat [64];
    logic [4:0]  wr_rg  [64];

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: operands appear the cycle after a granted read
    always @(posedge clk) begin
        if (bus.rd_en && bus.rd_gnt) begin
            bus.rd_data_a <= opa[bus.rd_idx];
            bus.rd_data_b <= opb[bus.rd_idx];
        end
    end

    // Drive grant for the current cycle and log DUT outputs mid-cycle
    always @(negedge clk) begin
        mon_rel = cyc - t0;
        bus.rd_gnt = !(mon_rel >= 0 && mon_rel < 32 && deny[mon_rel]);
        if (bus.rd_en && rd_n < 64) begin
            rd_rel[rd_n] = mon_rel;
            rd_ix[rd_n]  = bus.rd_idx;
            rd_n++;
        end
        if (bus.wr_en && wr_n < 64) begin
            wr_rel[wr_n] = mon_rel;
            wr_ix[wr_n]  = bus.wr_idx;
            wr_dat[wr_n] = bus.wr_data;
            wr_rg[wr_n]  = bus.wr_reg;
            wr_n++;
        end
        if (bus.done) begin
            done_n++;
            done_rel = mon_rel;
            done_err = bus.err;
        end
        if (bus.cmd_ready && rdy_rel < 0 && mon_rel > 0) rdy_rel = mon_rel;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        rd_n = 0; wr_n = 0; done_n = 0; done_rel = -1; done_err = 1'b0; rdy_rel = -1;
    endtask

    // Issue one command (accept cycle is relative cycle 0) and wait for done
    task automatic run_cmd(input logic sub, input logic [1:0] pack, input logic [4:0] vd,
                           input logic [4:0] va, input logic [4:0] vb, input logic [4:0] vl);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_sub   = sub;
        bus.cmd_pack  = pack;
        bus.cmd_vd    = vd;
        bus.cmd_va    = va;
        bus.cmd_vb    = vb;
        bus.cmd_vl    = vl;
        t0 = cyc;
        clear_logs();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done_n != 0) break;
            @(negedge clk);
        end
        if (done_n == 0) chk("done_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        string       nm;
        logic        sub;
        logic [1:0]  pack;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int          exp_rel [4];
        logic [31:0] exp_dat [4];

        tbl[0] = '{"word_sub",     1'b1, 2'b00, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
        tbl[1] = '{"byte_add",     1'b0, 2'b10, 32'h01FF_7F80, 32'h0101_0101, 32'h0200_8081};
        tbl[2] = '{"half_sub",     1'b1, 2'b01, 32'h0000_0000, 32'h0001_0001, 32'hFFFF_FFFF};
        tbl[3] = '{"word_add_wrap",1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tbl[4] = '{"half_add",     1'b0, 2'b01, 32'h0001_FFFF, 32'h0001_0001, 32'h0002_0000};
        tbl[5] = '{"byte_sub",     1'b1, 2'b10, 32'h0001_0280, 32'h0101_0101, 32'hFF00_017F};
        tbl[6] = '{"word_sub_pos", 1'b1, 2'b00, 32'h0000_0010, 32'h0000_0003, 32'h0000_000D};
        tbl[7] = '{"half_sub_hi",  1'b1, 2'b01, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_0000};

        bus.cmd_valid = 1'b0; bus.cmd_sub = 1'b0; bus.cmd_pack = 2'b00;
        bus.cmd_vd = '0; bus.cmd_va = '0; bus.cmd_vb = '0; bus.cmd_vl = '0;
        bus.rd_data_a = '0; bus.rd_data_b = '0;
        for (int i = 0; i < 16; i++) begin opa[i] = '0; opb[i] = '0; end
        clear_logs();

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rd_en",     32'(bus.rd_en),     32'd0);
        chk("rst_wr_en",     32'(bus.wr_en),     32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_wr_data",   bus.wr_data,        32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Word sub, VL=3, full timing
        for (int i = 0; i < 3; i++) begin opa[i] = 32'(5 + 16 * i); opb[i] = 32'd7; end
        run_cmd(1'b1, 2'b00, 5'd9, 5'd1, 5'd2, 5'd3);
        chk("vl3_rd_count", 32'(rd_n), 32'd3);
        chk("vl3_rd0_cycle", 32'(rd_rel[0]), 32'd1);
        chk("vl3_rd2_cycle", 32'(rd_rel[2]), 32'd3);
        chk("vl3_rd2_idx", 32'(rd_ix[2]), 32'd2);
        chk("vl3_wr_count", 32'(wr_n), 32'd3);
        chk("vl3_wr0_cycle", 32'(wr_rel[0]), 32'd3);
        chk("vl3_wr2_cycle", 32'(wr_rel[2]), 32'd5);
        chk("vl3_wr0_data", wr_dat[0], 32'hFFFF_FFFE);
        chk("vl3_wr1_data", wr_dat[1], 32'h0000_000E);
        chk("vl3_wr2_data", wr_dat[2], 32'h0000_001E);
        chk("vl3_wr_reg", 32'(wr_rg[0]), 32'd9);
        chk("vl3_done_cycle", 32'(done_rel), 32'd6);
        chk("vl3_done_count", 32'(done_n), 32'd1);
        chk("vl3_ready_cycle", 32'(rdy_rel), 32'd7);

        // Arithmetic table, VL=1 each
        for (int i = 0; i < 8; i++) begin
            opa[0] = tbl[i].a;
            opb[0] = tbl[i].b;
            run_cmd(tbl[i].sub, tbl[i].pack, 5'd4, 5'd5, 5'd6, 5'd1);
            chk($sformatf("%s_data", tbl[i].nm), wr_dat[0], tbl[i].exp);
            chk($sformatf("%s_wr_count", tbl[i].nm), 32'(wr_n), 32'd1);
            chk($sformatf("%s_done_cycle", tbl[i].nm), 32'(done_rel), 32'd4);
            chk($sformatf("%s_err", tbl[i].nm), 32'(done_err), 32'd0);
        end

        // Grant withheld on cycles 2 and 3 of a VL=4 run
        for (int i = 0; i < 4; i++) begin opa[i] = 32'(256 * i + 1); opb[i] = 32'h10; end
        exp_rel = '{3, 6, 7, 8};
        exp_dat = '{32'h11, 32'h111, 32'h211, 32'h311};
        deny = 32'h0000_000C;
        run_cmd(1'b0, 2'b00, 5'd7, 5'd8, 5'd9, 5'd4);
        deny = '0;
        chk("stall_rd_count", 32'(rd_n), 32'd6);
        chk("stall_idx_c2", 32'(rd_ix[1]), 32'd1);
        chk("stall_idx_c3", 32'(rd_ix[2]), 32'd1);
        chk("stall_idx_c4", 32'(rd_ix[3]), 32'd1);
        chk("stall_idx_c6", 32'(rd_ix[5]), 32'd3);
        chk("stall_wr_count", 32'(wr_n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall_wr%0d_cycle", k), 32'(wr_rel[k]), 32'(exp_rel[k]));
            chk($sformatf("stall_wr%0d_idx", k), 32'(wr_ix[k]), 32'(k));
            chk($sformatf("stall_wr%0d_data", k), wr_dat[k], exp_dat[k]);
        end
        chk("stall_done_cycle", 32'(done_rel), 32'd9);

        // VL=0 and illegal pack
        run_cmd(1'b0, 2'b00, 5'd1, 5'd2, 5'd3, 5'd0);
        chk("vl0_done_cycle", 32'(done_rel), 32'd1);
        chk("vl0_rd_count", 32'(rd_n), 32'd0);
        chk("vl0_wr_count", 32'(wr_n), 32'd0);
        chk("vl0_err", 32'(done_err), 32'd0);
        run_cmd(1'b0, 2'b11, 5'd1, 5'd2, 5'd3, 5'd5);
        chk("ill_done_cycle", 32'(done_rel), 32'd1);
        chk("ill_err", 32'(done_err), 32'd1);
        chk("ill_rd_count", 32'(rd_n), 32'd0);
        chk("ill_wr_count", 32'(wr_n), 32'd0);
        chk("ill_done_count", 32'(done_n), 32'd1);

        // Full length with vd == va
        for (int i = 0; i < 16; i++) begin opa[i] = 32'(i); opb[i] = 32'h1000; end
        run_cmd(1'b0, 2'b00, 5'd3, 5'd3, 5'd4, 5'd16);
        chk("full_rd_count", 32'(rd_n), 32'd16);
        chk("full_wr_count", 32'(wr_n), 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("full_rd%0d_idx", k), 32'(rd_ix[k]), 32'(k));
            chk($sformatf("full_wr%0d_idx", k), 32'(wr_ix[k]), 32'(k));
            chk($sformatf("full_wr%0d_data", k), wr_dat[k], 32'(32'h1000 + k));
        end
        chk("full_wr_reg", 32'(wr_rg[15]), 32'd3);
        chk("full_last_wr_cycle", 32'(wr_rel[15]), 32'd18);
        chk("full_done_cycle", 32'(done_rel), 32'd19);

        // VL above the maximum clamps to 16
        run_cmd(1'b0, 2'b00, 5'd3, 5'd5, 5'd4, 5'd20);
        chk("clamp_wr_count", 32'(wr_n), 32'd16);
        chk("clamp_last_idx", 32'(wr_ix[15]), 32'd15);

        // Reset in the middle of a run after two grants
        for (int i = 0; i < 8; i++) begin opa[i] = 32'(i + 1); opb[i] = 32'd1; end
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_sub = 1'b0; bus.cmd_pack = 2'b00;
        bus.cmd_vd = 5'd2; bus.cmd_va = 5'd2; bus.cmd_vb = 5'd6; bus.cmd_vl = 5'd8;
        t0 = cyc;
        clear_logs();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_wr_en", 32'(bus.wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(bus.rd_en), 32'd0);
        chk("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mid_rst_rd_idx", 32'(bus.rd_idx), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (8) @(negedge clk);
        chk("post_rst_wr_count", 32'(wr_n), 32'd0);
        chk("post_rst_done_count", 32'(done_n), 32'd0);
        chk("post_rst_rd_count", 32'(rd_n), 32'd0);
        opa[0] = 32'h10; opb[0] = 32'h1;
        opa[1] = 32'h20; opb[1] = 32'h2;
        run_cmd(1'b0, 2'b00, 5'd2, 5'd3, 5'd4, 5'd2);
        chk("after_rst_rd0_idx", 32'(rd_ix[0]), 32'd0);
        chk("after_rst_wr_count", 32'(wr_n), 32'd2);
        chk("after_rst_wr0_idx", 32'(wr_ix[0]), 32'd0);
        chk("after_rst_wr1_data", wr_dat[1], 32'h22);
        chk("after_rst_done_cycle", 32'(done_rel), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
